// File: rtl/multi_chan_timer.sv
// Bank of independent programmable countdown timers with one-shot/periodic modes,
// per-channel expiry pulse, sticky flag, busy status, combined interrupt and count readback.
module multi_chan_timer #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int CH_SEL_W   = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Cfg_We,
  input  logic [CH_SEL_W-1:0]   Cfg_Ch,
  input  logic [DATA_WIDTH-1:0] Cfg_Load,
  input  logic                  Cfg_Mode,
  input  logic [CHANNELS-1:0]   Start,
  input  logic [CHANNELS-1:0]   Stop,
  input  logic [CHANNELS-1:0]   Flag_Clr,
  input  logic [CH_SEL_W-1:0]   Rd_Ch,
  output logic [DATA_WIDTH-1:0] Rd_Count,
  output logic [CHANNELS-1:0]   Busy,
  output logic [CHANNELS-1:0]   Expire,
  output logic [CHANNELS-1:0]   Flag,
  output logic                  Irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                r_state     [CHANNELS];
  state_t                w_state_nxt [CHANNELS];
  logic [DATA_WIDTH-1:0] r_load      [CHANNELS];
  logic [DATA_WIDTH-1:0] r_count     [CHANNELS];
  logic [DATA_WIDTH-1:0] w_count_nxt [CHANNELS];
  logic [CHANNELS-1:0]   r_mode;
  logic [CHANNELS-1:0]   r_expire;
  logic [CHANNELS-1:0]   r_flag;
  logic [CHANNELS-1:0]   w_expire_nxt;
  logic [CHANNELS-1:0]   w_flag_nxt;
  logic [CHANNELS-1:0]   w_cfg_sel;

  // Out-of-range channel numbers never match, so such writes are dropped.
  always_comb begin
    w_cfg_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cfg_sel[i] = Cfg_We && (Cfg_Ch == CH_SEL_W'(i));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_load[i] <= '0;
      end
      r_mode <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_cfg_sel[i]) begin
          r_load[i] <= Cfg_Load;
          r_mode[i] <= Cfg_Mode;
        end
      end
    end
  end

  // Priority per channel: Stop > Start > expiry > decrement. Start reads the
  // pre-edge Load, so a same-edge config write only affects later starts.
  always_comb begin
    w_expire_nxt = '0;
    w_flag_nxt   = r_flag & ~Flag_Clr;
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_count_nxt[i] = r_count[i];
      if (Stop[i]) begin
        w_state_nxt[i] = ST_IDLE;
      end else if (Start[i]) begin
        w_state_nxt[i] = ST_RUN;
        w_count_nxt[i] = r_load[i];
      end else if (r_state[i] == ST_RUN) begin
        if (r_count[i] == '0) begin
          w_expire_nxt[i] = 1'b1;
          w_flag_nxt[i]   = 1'b1;
          if (r_mode[i]) begin
            w_count_nxt[i] = r_load[i];
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end else begin
          w_count_nxt[i] = r_count[i] - DATA_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= ST_IDLE;
        r_count[i] <= '0;
      end
      r_expire <= '0;
      r_flag   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_count[i] <= w_count_nxt[i];
      end
      r_expire <= w_expire_nxt;
      r_flag   <= w_flag_nxt;
    end
  end

  always_comb begin
    Rd_Count = '0;
    Busy     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      Busy[i] = (r_state[i] == ST_RUN);
      if (Rd_Ch == CH_SEL_W'(i)) begin
        Rd_Count = r_count[i];
      end
    end
  end

  assign Expire = r_expire;
  assign Flag   = r_flag;
  assign Irq    = |r_flag;

endmodule

// File: tb/tb_multi_chan_timer.sv
// Self-checking bench for multi_chan_timer: directed scenarios plus random traffic,
// checked against a timestamp-based reference model.
module tb_multi_chan_timer;
  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int SW  = 3;
  localparam int SBW = 3 * NC + 1;

  logic          Clk      = 1'b0;
  logic          Rst_n    = 1'b0;
  logic          Cfg_We   = 1'b0;
  logic [SW-1:0] Cfg_Ch   = '0;
  logic [DW-1:0] Cfg_Load = '0;
  logic          Cfg_Mode = 1'b0;
  logic [NC-1:0] Start    = '0;
  logic [NC-1:0] Stop     = '0;
  logic [NC-1:0] Flag_Clr = '0;
  logic [SW-1:0] Rd_Ch    = '0;
  logic [DW-1:0] Rd_Count;
  logic [NC-1:0] Busy;
  logic [NC-1:0] Expire;
  logic [NC-1:0] Flag;
  logic          Irq;

  multi_chan_timer #(.DATA_WIDTH(DW), .CHANNELS(NC), .CH_SEL_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch),
    .Cfg_Load(Cfg_Load), .Cfg_Mode(Cfg_Mode), .Start(Start), .Stop(Stop),
    .Flag_Clr(Flag_Clr), .Rd_Ch(Rd_Ch), .Rd_Count(Rd_Count), .Busy(Busy),
    .Expire(Expire), .Flag(Flag), .Irq(Irq)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  // Reference model: a running channel remembers the edge it was (re)loaded
  // and the value loaded; its count is derived from elapsed edges.
  int errors = 0;
  int checks = 0;
  int e      = 0;
  int m_load [NC];
  int m_base [NC];
  int m_t0   [NC];
  int m_frz  [NC];
  bit m_mode [NC];
  bit m_run  [NC];
  bit m_flag [NC];
  bit m_exp  [NC];
  logic [SBW-1:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_load[c] = 0; m_base[c] = 0; m_t0[c] = 0; m_frz[c] = 0;
      m_mode[c] = 0; m_run[c] = 0; m_flag[c] = 0; m_exp[c] = 0;
    end
  endtask

  function automatic int model_count(int c);
    return m_run[c] ? m_base[c] - (e - m_t0[c]) : m_frz[c];
  endfunction

  task automatic model_push();
    logic [NC-1:0] ee, eb, ef;
    for (int c = 0; c < NC; c++) begin
      ee[c] = m_exp[c]; eb[c] = m_run[c]; ef[c] = m_flag[c];
    end
    exp_q.push_back({|ef, ef, eb, ee});
  endtask

  task automatic model_step();
    e++;
    if (!Rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < NC; c++) begin
        m_exp[c] = 0;
        if (Stop[c]) begin
          if (m_run[c]) m_frz[c] = m_base[c] - (e - 1 - m_t0[c]);
          m_run[c] = 0;
        end else if (Start[c]) begin
          m_base[c] = m_load[c]; m_t0[c] = e; m_run[c] = 1;
        end else if (m_run[c] && (e - m_t0[c] == m_base[c] + 1)) begin
          m_exp[c] = 1;
          if (m_mode[c]) begin
            m_base[c] = m_load[c]; m_t0[c] = e;
          end else begin
            m_run[c] = 0; m_frz[c] = 0;
          end
        end
        if (m_exp[c]) m_flag[c] = 1;
        else if (Flag_Clr[c]) m_flag[c] = 0;
      end
      if (Cfg_We && int'(Cfg_Ch) < NC) begin
        m_load[int'(Cfg_Ch)] = int'(Cfg_Load);
        m_mode[int'(Cfg_Ch)] = Cfg_Mode;
      end
    end
    model_push();
  endtask

  // Scoreboard compare
  task automatic check_outputs(string tag);
    logic [SBW-1:0] v;
    logic [DW-1:0]  ec;
    v = exp_q.pop_front();
    checks++;
    assert (Expire === v[NC-1:0]) else begin
      errors++; $error("FAIL %s expire got=%b exp=%b", tag, Expire, v[NC-1:0]);
    end
    checks++;
    assert (Busy === v[2*NC-1:NC]) else begin
      errors++; $error("FAIL %s busy got=%b exp=%b", tag, Busy, v[2*NC-1:NC]);
    end
    checks++;
    assert (Flag === v[3*NC-1:2*NC]) else begin
      errors++; $error("FAIL %s flag got=%b exp=%b", tag, Flag, v[3*NC-1:2*NC]);
    end
    checks++;
    assert (Irq === v[3*NC]) else begin
      errors++; $error("FAIL %s irq got=%b exp=%b", tag, Irq, v[3*NC]);
    end
    for (int r = 0; r <= NC; r++) begin
      Rd_Ch = SW'(r);
      #1;
      ec = (r < NC) ? DW'(model_count(r)) : '0;
      checks++;
      assert (Rd_Count === ec) else begin
        errors++; $error("FAIL %s count[%0d] got=%0d exp=%0d", tag, r, Rd_Count, ec);
      end
    end
  endtask

  // Driver tasks
  task automatic tick(string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_outputs(tag);
    Start = '0; Stop = '0; Flag_Clr = '0; Cfg_We = 1'b0;
  endtask

  task automatic ticks(int n, string tag);
    repeat (n) tick(tag);
  endtask

  task automatic cfg(int ch, int load, bit mode);
    Cfg_We = 1'b1; Cfg_Ch = SW'(ch); Cfg_Load = DW'(load); Cfg_Mode = mode;
  endtask

  initial begin
    model_reset();
    #1;
    model_push();
    check_outputs("reset");
    ticks(2, "reset_hold");
    Rst_n = 1'b1;
    ticks(20, "idle");

    // One-shot, then flag clear
    cfg(0, 5, 0);       tick("cfg0");
    Start[0] = 1'b1;    tick("oneshot_start");
    ticks(8, "oneshot_run");
    Flag_Clr[0] = 1'b1; tick("flag_clr");
    tick("after_clr");

    // Periodic, reload change mid-period
    cfg(1, 3, 1);       tick("cfg1");
    Start[1] = 1'b1;    tick("per_start");
    ticks(21, "per_run");
    cfg(1, 1, 1);       tick("per_reload_wr");
    ticks(12, "per_short");
    Stop[1] = 1'b1;     tick("per_stop");

    // Retrigger at count 0, then stop vs start
    cfg(2, 4, 0);       tick("cfg2");
    Start[2] = 1'b1;    tick("rt_start");
    ticks(4, "rt_run");
    Start[2] = 1'b1;    tick("retrigger");
    ticks(2, "rt_run2");
    Start[2] = 1'b1; Stop[2] = 1'b1; tick("stop_start");
    ticks(3, "frozen");

    // Load 0 periodic; flag clear coincident with expiry
    cfg(3, 0, 1);       tick("cfg3");
    Start[3] = 1'b1;    tick("l0_start");
    ticks(5, "l0_run");
    Flag_Clr[3] = 1'b1; tick("clr_vs_set");
    Stop[3] = 1'b1;     tick("l0_stop");

    // Out-of-range config write
    cfg(NC, 99, 1);     tick("cfg_oob");
    Start = '1;         tick("oob_start");
    Stop = '1;          tick("oob_stop");

    // Concurrent channels
    Flag_Clr = '1;      tick("clr_all");
    cfg(0, 2, 0);  tick("cc_cfg0");
    cfg(1, 7, 0);  tick("cc_cfg1");
    cfg(2, 0, 0);  tick("cc_cfg2");
    cfg(3, 15, 0); tick("cc_cfg3");
    Start = '1;    tick("cc_start");
    ticks(20, "cc_run");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < NC; c++) begin
        Start[c]    = ($urandom_range(0, 7) == 0);
        Stop[c]     = ($urandom_range(0, 15) == 0);
        Flag_Clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 3) == 0)
        cfg($urandom_range(0, NC), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      tick("random");
    end

    // Reset while counting
    cfg(0, 10, 1);      tick("mr_cfg");
    Start[0] = 1'b1;    tick("mr_start");
    ticks(3, "mr_run");
    Rst_n = 1'b0;
    #1;
    model_reset();
    model_push();
    check_outputs("async_rst");
    tick("rst_held");
    Rst_n = 1'b1;
    ticks(3, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_chan_timer.md
Name: multi_chan_timer

Overview:
- Bank of independent programmable countdown timers sharing one clock; a parametrised successor to the single fixed-reload down-counter timers.
- Each channel has:
  - a load value and mode, written through a shared configuration port;
  - one-shot or periodic operation;
  - a single-cycle expiry pulse, a sticky flag, and a busy status.
- A combined interrupt output and a count readback mux feed the system controller.

Parameters:
- DATA_WIDTH, 32, width of load value and per-channel counter.
- CHANNELS, 4, number of independent timer channels (1..16).
- CH_SEL_W, 2, width of channel select fields; must satisfy 2^CH_SEL_W >= CHANNELS.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Cfg_We  input  1  configuration write strobe.
- Cfg_Ch  input  CH_SEL_W  channel addressed by the write.
- Cfg_Load  input  DATA_WIDTH  load value written to Load[Cfg_Ch].
- Cfg_Mode  input  1  0 = one-shot, 1 = periodic; written to Mode[Cfg_Ch].
- Start  input  CHANNELS  per-channel start/retrigger, level sampled each edge.
- Stop  input  CHANNELS  per-channel stop.
- Flag_Clr  input  CHANNELS  per-channel sticky flag clear.
- Rd_Ch  input  CH_SEL_W  channel selected for count readback.
- Rd_Count  output  DATA_WIDTH  Count[Rd_Ch], combinational; 0 if Rd_Ch >= CHANNELS.
- Busy  output  CHANNELS  channel in RUN state (registered).
- Expire  output  CHANNELS  one-cycle registered pulse on expiry.
- Flag  output  CHANNELS  sticky expiry flag.
- Irq  output  1  OR of all Flag bits.

Behaviour:
- Reset (async, Rst_n low):
  - all Load, Count, Mode, Busy, Expire, Flag = 0;
  - all channels IDLE; Irq = 0.
- Config:
  - On an edge with Cfg_We = 1 and Cfg_Ch < CHANNELS: Load[Cfg_Ch] and Mode[Cfg_Ch] are updated.
  - Cfg_Ch >= CHANNELS: write ignored.
  - A write to a running channel does not touch Count. The new Load/Mode take effect at the next start or periodic reload.
- Per-channel FSM, IDLE/RUN, evaluated each edge. Priority is Stop > Start > expiry > decrement.
  - Stop = 1: state IDLE, Busy = 0, Count holds its value, no Expire. Stop wins over a simultaneous Start.
  - Start = 1 (IDLE or RUN): Count <= Load, state RUN, Busy = 1.
    - In RUN this is a retrigger; it suppresses any expiry due on that edge.
    - Config written on the same edge is not used; the old Load is loaded.
  - RUN with Count == 0: Expire <= 1 for that cycle and Flag <= 1.
    - One-shot: state IDLE, Busy = 0, Count stays 0.
    - Periodic: Count <= Load, stays RUN.
  - RUN with Count != 0: Count <= Count - 1, wrap impossible.
  - IDLE with no Start: Count holds.
- Timing:
  - Start sampled at edge 0 with Load = L gives Expire high during the cycle after edge L+1.
  - One-shot busy time is L+1 cycles.
  - Periodic period is L+1 cycles; L = 0 in periodic mode gives Expire every cycle.
- Expire is 0 on every edge not listed above.
- Flag: set on expiry and held until an edge with Flag_Clr = 1. If expiry and Flag_Clr occur on the same edge, set wins and Flag stays 1. Start does not clear Flag.
- Irq is registered-equivalent: it is the OR of registered Flag bits, with no extra latency.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset asserted mid-count: everything returns to reset values immediately; no Expire is generated.

Test Plan:
- Reset then idle 20 cycles -> Busy = 0, Expire = 0, Flag = 0, Irq = 0, Rd_Count = 0 on all channels.
- One-shot expiry and flag clear:
  - Stimulus: write ch0 Load = 5, Mode = 0; pulse Start[0] at edge 0.
  - Response: Busy[0] = 1 from edge 0; Rd_Count steps 5,4,3,2,1,0; Expire[0] pulses exactly once after edge 6; Busy[0] = 0 after edge 6; Flag[0] = 1 and Irq = 1 persist.
  - Then Flag_Clr[0] -> Flag[0] = 0 and Irq = 0.
- Periodic mode:
  - Stimulus: ch1 Load = 3, Mode = 1, Start[1].
  - Response: Expire[1] every 4 cycles across 5 periods.
  - Write Load = 1 mid-period -> current period still 4 cycles, following periods 2 cycles.
- Retrigger and Stop:
  - ch2 Load = 4 started; Start[2] re-pulsed when Count = 0 -> no Expire that cycle, Count = 4 again.
  - Stop[2] and Start[2] on the same edge -> IDLE, Count frozen, Busy[2] = 0.
- Edge cases:
  - Load = 0 periodic -> Expire high continuously.
  - Flag_Clr coincident with expiry -> Flag stays 1.
  - Cfg_Ch = CHANNELS (when 2^CH_SEL_W > CHANNELS) -> no channel changes.
  - Rst_n asserted while counting -> all outputs 0 immediately.
- Concurrency: all channels started together with Load values 2, 7, 0, 15 -> each Expire bit fires at its own L+1 delay, independently.
